// File: rtl/wl_afifo_pkg.sv
// Shared helpers for the wl_afifo read and write controllers: gray conversion,
// depth derivation and reset values of the status flags.
package wl_afifo_pkg;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR fold; the RTL uses wl_afifo_gray2bin, this is for reference/const use.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

    localparam logic RST_EMPTY     = 1'b1;
    localparam logic RST_AEMPTY    = 1'b1;
    localparam logic RST_UNDERFLOW = 1'b0;

endpackage

// File: rtl/wl_afifo_rd_ctrl_if.sv
// Read-side bus of the wl_afifo: reader requests, write-pointer input and read-side status.
interface wl_afifo_rd_ctrl_if #(parameter int ADDR_W = 3);

    logic              rclr;
    logic              re;
    logic [ADDR_W:0]   r_gray_wptr;
    logic [ADDR_W:0]   aempty_thr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   g_rptr;
    logic              rempty;
    logic              ralmost_empty;
    logic [ADDR_W:0]   rlevel;
    logic              underflow;
    logic              underflow_sticky;

    modport master (
        output rclr, re, r_gray_wptr, aempty_thr,
        input  raddr, g_rptr, rempty, ralmost_empty, rlevel, underflow, underflow_sticky
    );

    modport slave (
        input  rclr, re, r_gray_wptr, aempty_thr,
        output raddr, g_rptr, rempty, ralmost_empty, rlevel, underflow, underflow_sticky
    );

endinterface

// File: rtl/wl_afifo_gray2bin.sv
// Parametrised gray-to-binary converter (XOR prefix from the MSB down); shared with the write side.
module wl_afifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wl_afifo_rd_ctrl.sv
// Read-side pointer/flag controller of the wl_afifo async FIFO (rclk domain).
// Define WL_AFIFO_RD_SYNC_EN to synchronise the raw write pointer inside this block.
module wl_afifo_rd_ctrl
    import wl_afifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_b,
    wl_afifo_rd_ctrl_if.slave rd
);

    localparam int PW = ADDR_W + 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("wl_afifo_rd_ctrl: SYNC_STAGES must be >= 2");
    end

    logic [PW-1:0] wptr_s;
    logic [PW-1:0] wbin;
    logic [PW-1:0] bin_rptr;
    logic [PW-1:0] g_rptr_q;
    logic [PW-1:0] rlevel_q;
    logic          rempty_q;
    logic          aempty_q;
    logic          underflow_q;
    logic          sticky_q;

`ifdef WL_AFIFO_RD_SYNC_EN
    logic [PW-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else if (rd.rclr) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rd.r_gray_wptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wptr_s = sync_q[SYNC_STAGES-1];
`else
    assign wptr_s = rd.r_gray_wptr;
`endif

    wl_afifo_gray2bin #(.W(PW)) u_g2b (
        .gray (wptr_s),
        .bin  (wbin)
    );

    logic          rd_ok;
    logic [PW-1:0] bin_nxt;
    logic [PW-1:0] gray_nxt;
    logic [PW-1:0] level_nxt;

    always_comb begin
        rd_ok     = rd.re & ~rempty_q;
        bin_nxt   = bin_rptr + PW'(rd_ok);
        gray_nxt  = PW'(bin2gray(32'(bin_nxt)));
        level_nxt = wbin - bin_nxt;
    end

    // Flags are computed from the post-read pointer so the last read empties without a bubble.
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            bin_rptr    <= '0;
            g_rptr_q    <= '0;
            rlevel_q    <= '0;
            rempty_q    <= RST_EMPTY;
            aempty_q    <= RST_AEMPTY;
            underflow_q <= RST_UNDERFLOW;
            sticky_q    <= 1'b0;
        end else if (rd.rclr) begin
            bin_rptr    <= '0;
            g_rptr_q    <= '0;
            rlevel_q    <= '0;
            rempty_q    <= RST_EMPTY;
            aempty_q    <= RST_AEMPTY;
            underflow_q <= RST_UNDERFLOW;
            sticky_q    <= 1'b0;
        end else begin
            bin_rptr    <= bin_nxt;
            g_rptr_q    <= gray_nxt;
            rlevel_q    <= level_nxt;
            rempty_q    <= (gray_nxt == wptr_s);
            aempty_q    <= (level_nxt <= rd.aempty_thr);
            underflow_q <= rd.re & rempty_q;
            sticky_q    <= sticky_q | (rd.re & rempty_q);
        end
    end

    assign rd.raddr            = bin_rptr[ADDR_W-1:0];
    assign rd.g_rptr           = g_rptr_q;
    assign rd.rempty           = rempty_q;
    assign rd.ralmost_empty    = aempty_q;
    assign rd.rlevel           = rlevel_q;
    assign rd.underflow        = underflow_q;
    assign rd.underflow_sticky = sticky_q;

endmodule

// File: tb/tb_wl_afifo_rd_ctrl.sv
// Bench for wl_afifo_rd_ctrl: directed scenarios plus random traffic against a count-based model.
module tb_wl_afifo_rd_ctrl;

`ifdef WL_AFIFO_RD_SYNC_EN
    localparam int SS  = 3;
    localparam int LAT = 3;
`else
    localparam int SS  = 2;
    localparam int LAT = 0;
`endif
    localparam int DEPTH = 8;

    logic rclk;
    logic rrst_b;

    wl_afifo_rd_ctrl_if #(.ADDR_W(3)) ifc ();

    wl_afifo_rd_ctrl #(.ADDR_W(3), .SYNC_STAGES(SS)) dut (
        .rclk   (rclk),
        .rrst_b (rrst_b),
        .rd     (ifc.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_vec;
    int n_err;

    // Model: total words written by the bench, total accepted reads, and the
    // written count as it becomes visible through the synchroniser delay.
    int m_wr, m_rd, m_level;
    int pipe [0:7];
    bit m_empty, m_ae, m_uf, m_sticky;

    function automatic int gray(input int x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rd = 0; m_level = 0;
        m_empty = 1; m_ae = 1; m_uf = 0; m_sticky = 0;
        for (int i = 0; i < 8; i++) pipe[i] = 0;
    endtask

    task automatic model_edge();
        int vis;
        bit acc;
        if (ifc.rclr) begin
            model_clear();
        end else begin
            if (LAT == 0) vis = m_wr;
            else begin
                vis = pipe[(LAT > 0) ? LAT - 1 : 0];
                for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = m_wr;
            end
            acc      = ifc.re && !m_empty;
            m_uf     = ifc.re && m_empty;
            m_sticky = m_sticky | m_uf;
            m_rd     = m_rd + (acc ? 1 : 0);
            m_level  = vis - m_rd;
            m_empty  = (m_level == 0);
            m_ae     = (m_level <= int'(ifc.aempty_thr));
        end
    endtask

    task automatic check_all();
        chk("raddr",     32'(ifc.raddr),            32'(m_rd % DEPTH));
        chk("g_rptr",    32'(ifc.g_rptr),           32'(gray(m_rd % (2*DEPTH))));
        chk("rempty",    32'(ifc.rempty),           32'(m_empty));
        chk("ralmost",   32'(ifc.ralmost_empty),    32'(m_ae));
        chk("rlevel",    32'(ifc.rlevel),           32'(m_level));
        chk("underflow", 32'(ifc.underflow),        32'(m_uf));
        chk("sticky",    32'(ifc.underflow_sticky), 32'(m_sticky));
    endtask

    task automatic step();
        @(posedge rclk);
        model_edge();
        @(negedge rclk);
        check_all();
    endtask

    // Called at a negedge; a write is dropped if it would overfill the FIFO.
    task automatic drive(input bit r, input bit w);
        ifc.re = r;
        if (w && (m_wr - m_rd) < DEPTH) m_wr++;
        ifc.r_gray_wptr = 4'(gray(m_wr % (2*DEPTH)));
    endtask

    task automatic clear_both(input bit r);
        ifc.rclr = 1'b1;
        ifc.re = r;
        m_wr = 0;
        ifc.r_gray_wptr = '0;
        step();
        ifc.rclr = 1'b0;
    endtask

    initial begin
        int cnt;
        n_vec = 0; n_err = 0;
        m_wr = 0;
        model_clear();
        rrst_b = 1'b0;
        ifc.rclr = 1'b0; ifc.re = 1'b0; ifc.r_gray_wptr = '0; ifc.aempty_thr = 4'd1;
        repeat (2) @(negedge rclk);
        check_all();
        rrst_b = 1'b1;

        // Underflow from reset
        drive(1, 0); step(); step();
        drive(0, 0); step();

        // Three writes (gray 1,3,2), then two reads with threshold 1
        for (int i = 0; i < 3; i++) begin drive(0, 1); step(); end
        drive(0, 0); repeat (LAT + 1) step();
        drive(1, 0); step(); step();
        drive(0, 0); step();
        drive(1, 0); step();
        drive(0, 0); step();

        // Fill to depth then read back-to-back
        for (int i = 0; i < DEPTH; i++) begin drive(0, 1); step(); end
        drive(0, 0); repeat (LAT + 1) step();
        for (int i = 0; i < DEPTH; i++) begin drive(1, 0); step(); end
        drive(0, 0); step(); step();

        // Simultaneous write/read pairs across the pointer wrap
        drive(0, 1); step(); drive(0, 1); step();
        drive(0, 0); repeat (LAT + 1) step();
        for (int i = 0; i < 20; i++) begin drive(1, 1); step(); end
        drive(0, 0); repeat (LAT + 1) step();

        // Level 5 with sticky set, then clear with a concurrent read
        for (int i = 0; i < 3; i++) begin drive(0, 1); step(); end
        drive(0, 0); repeat (LAT + 1) step();
        chk("lvl5", 32'(ifc.rlevel), 32'd5);
        clear_both(1'b1);
        ifc.re = 1'b0;
        step();

        // Write visibility latency
        drive(0, 1);
        cnt = 0;
        do begin
            step();
            cnt++;
            drive(0, 0);
        end while (ifc.rempty && cnt < 12);
        chk("empty_lat", 32'(cnt), 32'(LAT + 1));

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                ifc.aempty_thr = 4'($urandom_range(0, 8));
                clear_both(1'($urandom_range(0, 1)));
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
